// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and helpers for the stream mux.
// Provides the mode enum and the channel index width helper.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among req bits.
// Ports: req, ptr (last winner) in; gnt index, gnt_vld out.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt,
  output logic             gnt_vld
);

  int   idx;
  logic found;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = SEL_W'(idx);
      end
    end
  end

  assign gnt_vld = |req;

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel stream mux, select or round-robin.
// Ports: in_data/in_valid/in_ready, mode, sel, out_* stream.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  mode_e             md;
  logic              load;
  logic              gnt_vld;
  logic              rr_vld;
  logic              sel_vld;
  logic [SEL_W-1:0]  gnt;
  logic [SEL_W-1:0]  rr_gnt;
  logic [SEL_W-1:0]  ptr;
  logic [DATA_W-1:0] gnt_data;

  assign md   = mode_e'(mode);
  assign load = !out_valid || out_ready;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // Out-of-range sel matches no channel, so it never grants.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) sel_vld = in_valid[i];
    end
  end

  always_comb begin
    gnt     = sel;
    gnt_vld = sel_vld;
    unique case (md)
      MODE_SEL: begin
        gnt     = sel;
        gnt_vld = sel_vld;
      end
      MODE_RR: begin
        gnt     = rr_gnt;
        gnt_vld = rr_vld;
      end
    endcase
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready is masked by reset so nothing handshakes while held.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = rst_n && load && gnt_vld
                  && (gnt == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_W'(N_CH - 1);
    end else if (load) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt;
        if (md == MODE_RR) ptr <= gnt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of stream_mux_rr.
// Covers N_CH=4/W=8 and N_CH=3/W=16 instances.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic        a_mode;
  logic [1:0]  a_sel;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [47:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_valid;
  logic        b_out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .mode      (a_mode),
    .sel       (a_sel),
    .out_data  (a_out_data),
    .out_ch    (a_out_ch),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  stream_mux_rr #(.N_CH(3), .DATA_W(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_out_data),
    .out_ch    (b_out_ch),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_data   = 32'h13121110;
    a_in_valid  = 4'b0000;
    a_mode      = 1'b0;
    a_sel       = 2'd0;
    a_out_ready = 1'b1;
    b_in_data   = 48'hB002_B001_B000;
    b_in_valid  = 3'b000;
    b_mode      = 1'b0;
    b_sel       = 2'd3;
    b_out_ready = 1'b1;

    tick();
    tick();
    chk("rst_valid", a_out_valid, 0);
    chk("rst_data", a_out_data, 0);
    chk("rst_ch", a_out_ch, 0);
    chk("b_rst_valid", b_out_valid, 0);
    rst_n = 1'b1;

    a_mode     = 1'b1;
    a_in_valid = 4'b1111;
    #1;
    chk("rr0_ready", a_in_ready, 4'b0001);
    tick();
    chk("rr0_ch", a_out_ch, 0);
    chk("rr0_data", a_out_data, 8'h10);
    chk("rr0_valid", a_out_valid, 1);
    chk("rr1_ready", a_in_ready, 4'b0010);
    tick();
    chk("rr1_ch", a_out_ch, 1);
    tick();
    chk("rr2_ch", a_out_ch, 2);
    tick();
    chk("rr3_ch", a_out_ch, 3);
    chk("rr3_data", a_out_data, 8'h13);
    tick();
    chk("rr4_ch", a_out_ch, 0);
    chk("rr4_valid", a_out_valid, 1);

    rst_n = 1'b0;
    #1;
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_data", a_out_data, 0);
    chk("mrst_ch", a_out_ch, 0);
    chk("mrst_ready", a_in_ready, 0);
    tick();
    chk("mrst_hold_ready", a_in_ready, 0);
    chk("mrst_hold_valid", a_out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("prr0_ready", a_in_ready, 4'b0001);
    tick();
    chk("prr0_ch", a_out_ch, 0);
    tick();
    chk("prr1_ch", a_out_ch, 1);
    tick();
    chk("prr2_ch", a_out_ch, 2);
    tick();
    chk("prr3_ch", a_out_ch, 3);
    tick();
    chk("prr4_ch", a_out_ch, 0);

    a_mode     = 1'b0;
    a_sel      = 2'd2;
    a_in_valid = 4'b0100;
    a_in_data  = 32'h13A51110;
    #1;
    chk("sel_ready", a_in_ready, 4'b0100);
    tick();
    chk("sel_data", a_out_data, 8'hA5);
    chk("sel_ch", a_out_ch, 2);
    chk("sel_valid", a_out_valid, 1);
    a_sel = 2'd1;
    #1;
    chk("sel1_ready", a_in_ready, 0);
    tick();
    chk("sel1_valid", a_out_valid, 0);
    chk("sel1_data_hold", a_out_data, 8'hA5);
    chk("sel1_ch_hold", a_out_ch, 2);
    a_in_data = 32'h13121110;

    a_mode     = 1'b1;
    a_in_valid = 4'b1010;
    tick();
    chk("fair0_ch", a_out_ch, 1);
    tick();
    chk("fair1_ch", a_out_ch, 3);
    tick();
    chk("fair2_ch", a_out_ch, 1);
    tick();
    chk("fair3_ch", a_out_ch, 3);
    chk("fair3_data", a_out_data, 8'h13);

    a_in_valid  = 4'b1111;
    a_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", a_in_ready, 0);
      tick();
      chk("bp_ch", a_out_ch, 3);
      chk("bp_data", a_out_data, 8'h13);
      chk("bp_valid", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", a_in_ready, 4'b0001);
    tick();
    chk("bp_rel_ch", a_out_ch, 0);
    chk("bp_rel_valid", a_out_valid, 1);

    a_in_valid = 4'b0100;
    tick();
    chk("ms_rr_ch", a_out_ch, 2);
    a_mode     = 1'b0;
    a_sel      = 2'd0;
    a_in_valid = 4'b1111;
    tick();
    chk("ms_sel0_ch", a_out_ch, 0);
    tick();
    chk("ms_sel1_ch", a_out_ch, 0);
    a_mode = 1'b1;
    #1;
    chk("ms_back_ready", a_in_ready, 4'b1000);
    tick();
    chk("ms_back_ch", a_out_ch, 3);

    b_mode     = 1'b0;
    b_sel      = 2'd3;
    b_in_valid = 3'b111;
    #1;
    chk("b_sel3_ready", b_in_ready, 0);
    tick();
    chk("b_sel3_valid0", b_out_valid, 0);
    tick();
    chk("b_sel3_valid1", b_out_valid, 0);
    b_mode = 1'b1;
    #1;
    chk("b_rr0_ready", b_in_ready, 3'b001);
    tick();
    chk("b_rr0_ch", b_out_ch, 0);
    chk("b_rr0_data", b_out_data, 16'hB000);
    tick();
    chk("b_rr1_ch", b_out_ch, 1);
    tick();
    chk("b_rr2_ch", b_out_ch, 2);
    chk("b_rr2_data", b_out_data, 16'hB002);
    tick();
    chk("b_rr3_ch", b_out_ch, 0);
    chk("b_rr3_valid", b_out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with per-channel valid/ready handshakes and a registered output stage. It generalises the plain 4:1 select mux to arbitrary channel count and data width, and adds two modes: explicit-select, or round-robin arbitration among requesting channels. It sits between multiple producer streams and a single consumer, with one cycle of latency and full throughput.

## Interface
- `N_CH`, 4, number of input channels (≥2)
- `DATA_W`, 8, bits per channel
- `SEL_W`, `$clog2(N_CH)`, derived localparam, channel index width

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_data`  in  `N_CH*DATA_W`  channel i occupies bits `[i*DATA_W +: DATA_W]`
- `in_valid`  in  `N_CH`  per-channel valid
- `in_ready`  out  `N_CH`  per-channel ready, one-hot or zero
- `mode`  in  1  0 = MODE_SEL (use `sel`), 1 = MODE_RR (round-robin)
- `sel`  in  `SEL_W`  channel index used in MODE_SEL
- `out_data`  out  `DATA_W`  registered selected data
- `out_ch`  out  `SEL_W`  index of the channel that supplied `out_data`
- `out_valid`  out  1  output holds a beat
- `out_ready`  in  1  consumer accepts beat

## Operation
- `load = !out_valid || out_ready`: the output register may accept a new beat.
- Grant, combinational:
  - MODE_SEL: `gnt = sel`. `gnt_vld = in_valid[sel]`. If `sel >= N_CH`, then `gnt_vld = 0`.
  - MODE_RR: search starts at `ptr+1` and wraps modulo `N_CH`. The first channel with `in_valid` high wins. `gnt_vld = |in_valid`.
- `in_ready[i] = load && gnt_vld && (gnt == i)`. All other channels see ready low.
- When `load && gnt_vld`:
  - `out_data <= in_data[gnt]`
  - `out_ch <= gnt`
  - `out_valid <= 1`
  - In MODE_RR only, `ptr <= gnt`.
- When `load && !gnt_vld`: `out_valid <= 0`. `out_data` and `out_ch` hold.
- When `!load`: output is stalled. All registers hold and every `in_ready` is 0.
- `ptr` does not update in MODE_SEL. A switch to MODE_RR resumes from the retained `ptr`.
- `mode` and `sel` are sampled each cycle. A change affects only the grant in that cycle. A beat already in the output register is never altered.
- Producers must hold data stable while valid and not ready. The block does not check this.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ptr = N_CH-1`. After reset the first RR grant goes to channel 0.
- `in_ready` has a combinational path from `out_ready`, `in_valid`, `mode` and `sel`. There is no combinational path from `in_data` to any output.
- Latency: an accepted beat appears on `out_*` the cycle after the handshake.
- Throughput: one beat per cycle when `out_ready` is held high.
- Simultaneous consume and refill: when `out_valid && out_ready` and `gnt_vld` are true in the same cycle, the register reloads with no bubble.
- Wrap-around: with `ptr = N_CH-1`, the RR search starts at channel 0.
- Single requester: in MODE_RR it is granted every cycle.
- Reset asserted mid-transfer: all outputs go to their reset values immediately. The pending beat is dropped and `in_ready` goes 0 while reset is held.

## Structure
- Package `stream_mux_pkg` holds:
  - the `mode_e` enum: `MODE_SEL = 1'b0`, `MODE_RR = 1'b1`
  - a `clog2`-based `SEL_W` helper
- Sub-module `rr_arbiter`, parametrised by `N_CH`:
  - inputs `req[N_CH-1:0]` and `ptr`
  - outputs `gnt` index and `gnt_vld`
  - purely combinational
- The top level holds the output register, `ptr`, the mode mux and the ready fan-out.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream. Required: `out_valid=0`, `out_data=0`, `out_ch=0` and all `in_ready=0` without waiting for a clock edge. After release, RR with all channels valid grants channels 0, 1, 2, 3, 0 on successive cycles.
- **MODE_SEL:** `sel=2`, `in_valid=4'b0100`, channel 2 data `8'hA5`, `out_ready=1`. Required: `in_ready=4'b0100`, and next cycle `out_data=8'hA5`, `out_ch=2`, `out_valid=1`. Then set `sel=1` with `in_valid[1]=0`. Required: `out_valid` falls the following cycle.
- **RR fairness:** `in_valid=4'b1010` held, `out_ready=1`. Required: `out_ch` sequence 1, 3, 1, 3. No channel is granted twice while another is waiting.
- **Back-pressure:** `out_valid=1`, `out_ready=0` for 3 cycles, all channels valid. Required: `out_data` and `out_ch` stable and `in_ready=0`. On `out_ready=1`, a new beat loads in that same cycle with no bubble.
- **Mode switch:** RR grants channel 2 (`ptr=2`), then 2 cycles in MODE_SEL with `sel=0`, then back to MODE_RR with all valid. Required: the first RR grant after the switch is channel 3.
- **Parameter sweep:** `N_CH=3`, `DATA_W=16`. MODE_SEL with `sel=3`. Required: `in_ready=0` and `out_valid` stays 0. RR wrap order is 0, 1, 2, 0.
